// File: rtl/shim_sts_pkg.sv
// -----------------------------------------------------------------------------
// shim_sts_pkg
// Shared limits and elaboration-time helpers for the status synchronizer
// slice (shim_sts_filter, shim_sts_sync_sticky_if, shim_sts_sync_sticky).
// No ports; constants and constant functions only.
// -----------------------------------------------------------------------------
package shim_sts_pkg;

  localparam int MAX_GROUPS       = 32;
  localparam int MAX_CH_WIDTH     = 32;
  localparam int MIN_SYNC_DEPTH   = 2;
  localparam int MAX_SYNC_DEPTH   = 5;
  localparam int MAX_STABLE_COUNT = 15;

  // ceil(log2(value)); clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Stability counter width: must hold 0..stable_count.
  function automatic int cnt_w(input int stable_count);
    return (clog2(stable_count + 1) < 1) ? 1 : clog2(stable_count + 1);
  endfunction

  // Group index width; never narrower than one bit so a single-group
  // build still has a legal vector.
  function automatic int grp_w(input int num_groups);
    return (clog2(num_groups) < 1) ? 1 : clog2(num_groups);
  endfunction

  // LSB position of group 'grp' in a flattened NUM_GROUPS*width vector.
  function automatic int grp_lo(input int grp, input int width);
    return grp * width;
  endfunction

  localparam int CNT_W_MAX = cnt_w(MAX_STABLE_COUNT);

endpackage

// File: rtl/shim_sts_sync_sticky_if.sv
// -----------------------------------------------------------------------------
// shim_sts_sync_sticky_if
// Bundle between the foreign-domain status sources / AXI register bank and
// the status synchronizer.
//   sts_in      foreign-domain raw flags, group g = [g*CH_WIDTH +: CH_WIDTH]
//   clr_req     single-cycle clear strobe, clr_mask selects groups
//   clr_ack     one-cycle acknowledge, the cycle after each clr_req
//   sts_stable  filtered live flags
//   sts_sticky  latched flags
//   grp_any     per-group OR of sts_sticky
//   irq_pulse   one-cycle pulse on any new sticky bit
//   first_*     first-fault capture, present only with STS_FIRST_FAULT_EN
//
// Handshake: clr_req has no ready. Every cycle with clr_req=1 is accepted
// unconditionally and answered by clr_ack=1 exactly one cycle later, so N
// consecutive request cycles produce N consecutive ack cycles. clr_mask is
// only meaningful while clr_req=1; clr_mask=0 still acknowledges.
//
// master: driven by the register bank / sources. slave: the synchronizer.
// Optional feature macro: STS_FIRST_FAULT_EN.
// -----------------------------------------------------------------------------
interface shim_sts_sync_sticky_if #(
  parameter int NUM_GROUPS = 13,
  parameter int CH_WIDTH   = 8
);
  localparam int W = NUM_GROUPS * CH_WIDTH;

  logic [W-1:0]          sts_in;
  logic                  clr_req;
  logic [NUM_GROUPS-1:0] clr_mask;
  logic                  clr_ack;
  logic [W-1:0]          sts_stable;
  logic [W-1:0]          sts_sticky;
  logic [NUM_GROUPS-1:0] grp_any;
  logic                  irq_pulse;
`ifdef STS_FIRST_FAULT_EN
  logic                                             first_valid;
  logic [shim_sts_pkg::grp_w(NUM_GROUPS)-1:0]       first_grp;
  logic [CH_WIDTH-1:0]                              first_bits;
`endif

  modport master (
    output sts_in, clr_req, clr_mask,
    input  clr_ack, sts_stable, sts_sticky, grp_any, irq_pulse
`ifdef STS_FIRST_FAULT_EN
    , input first_valid, first_grp, first_bits
`endif
  );

  modport slave (
    input  sts_in, clr_req, clr_mask,
    output clr_ack, sts_stable, sts_sticky, grp_any, irq_pulse
`ifdef STS_FIRST_FAULT_EN
    , output first_valid, first_grp, first_bits
`endif
  );

endinterface

// File: rtl/shim_sts_filter.sv
// -----------------------------------------------------------------------------
// shim_sts_filter
// One status group: SYNC_DEPTH-flop synchronizer followed by a stability
// filter. The filtered value only moves after the synchronized sample has
// been identical for STABLE_COUNT further cycles.
// Ports:
//   clk, rst_n   destination clock, async active-low reset
//   din          raw group flags from the foreign domain
//   stable       filtered group flags (registered)
// -----------------------------------------------------------------------------
module shim_sts_filter
  import shim_sts_pkg::*;
#(
  parameter int SYNC_DEPTH   = 3,
  parameter int CH_WIDTH     = 8,
  parameter int STABLE_COUNT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_WIDTH-1:0] din,
  output logic [CH_WIDTH-1:0] stable
);

  localparam int               CNT_W    = cnt_w(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic [CH_WIDTH-1:0] sync_q [SYNC_DEPTH];
  logic [CH_WIDTH-1:0] sync_tail;
  logic [CH_WIDTH-1:0] cand;
  logic [CNT_W-1:0]    cnt;

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_tail = sync_q[SYNC_DEPTH-1];

  // Any differing sample reloads the candidate and restarts the count;
  // the output takes the candidate on the edge the count reaches
  // STABLE_COUNT, after which the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (sync_tail != cand) begin
      cand <= sync_tail;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_LAST) stable <= cand;
    end
  end

endmodule

// File: rtl/shim_sts_sync_sticky.sv
// -----------------------------------------------------------------------------
// shim_sts_sync_sticky
// Brings NUM_GROUPS x CH_WIDTH status flags from a foreign domain into the
// AXI domain: per-group synchronizer + stability filter, then per-bit sticky
// latch with a per-group masked clear, per-group summary, and a one-cycle
// interrupt pulse whenever any sticky bit is newly set.
// Ports:
//   aclk, aresetn  AXI clock, async-assert / sync-release active-low reset
//   bus (slave)    sts_in, clr_req, clr_mask in; clr_ack, sts_stable,
//                  sts_sticky, grp_any, irq_pulse out
// Optional feature macro STS_FIRST_FAULT_EN adds first_valid / first_grp /
// first_bits: the lowest-index group (and its new bits) of the first sticky
// event, held until a clear with every group selected.
// -----------------------------------------------------------------------------
module shim_sts_sync_sticky
  import shim_sts_pkg::*;
#(
  parameter int NUM_GROUPS   = 13,
  parameter int CH_WIDTH     = 8,
  parameter int SYNC_DEPTH   = 3,
  parameter int STABLE_COUNT = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  shim_sts_sync_sticky_if.slave   bus
);

  localparam int W = NUM_GROUPS * CH_WIDTH;

  logic [W-1:0]          stable;
  logic [W-1:0]          stable_prev;
  logic [W-1:0]          rise;
  logic [W-1:0]          clr_vec;
  logic [W-1:0]          sticky;
  logic [W-1:0]          sticky_next;
  logic [W-1:0]          new_bits;
  logic [NUM_GROUPS-1:0] grp_any_q;
  logic [NUM_GROUPS-1:0] grp_next;
  logic                  irq_q;
  logic                  ack_q;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    shim_sts_filter #(
      .SYNC_DEPTH   (SYNC_DEPTH),
      .CH_WIDTH     (CH_WIDTH),
      .STABLE_COUNT (STABLE_COUNT)
    ) u_filter (
      .clk    (aclk),
      .rst_n  (aresetn),
      .din    (bus.sts_in[g*CH_WIDTH +: CH_WIDTH]),
      .stable (stable[g*CH_WIDTH +: CH_WIDTH])
    );
  end

  // Only a 0->1 edge of the filtered flag sets sticky, so a flag that stays
  // high across a clear does not come straight back. Set beats clear.
  assign rise        = stable & ~stable_prev;
  assign sticky_next = (sticky & ~clr_vec) | rise;
  assign new_bits    = sticky_next & ~sticky;

  always_comb begin
    clr_vec  = '0;
    grp_next = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      clr_vec[grp_lo(g, CH_WIDTH) +: CH_WIDTH] = {CH_WIDTH{bus.clr_req & bus.clr_mask[g]}};
      grp_next[g] = |sticky_next[grp_lo(g, CH_WIDTH) +: CH_WIDTH];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stable_prev <= '0;
      sticky      <= '0;
      grp_any_q   <= '0;
      irq_q       <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      stable_prev <= stable;
      sticky      <= sticky_next;
      grp_any_q   <= grp_next;
      irq_q       <= |new_bits;
      ack_q       <= bus.clr_req;
    end
  end

  assign bus.sts_stable = stable;
  assign bus.sts_sticky = sticky;
  assign bus.grp_any    = grp_any_q;
  assign bus.irq_pulse  = irq_q;
  assign bus.clr_ack    = ack_q;

`ifdef STS_FIRST_FAULT_EN
  localparam int GRP_W = grp_w(NUM_GROUPS);

  logic                ff_valid;
  logic [GRP_W-1:0]    ff_grp;
  logic [GRP_W-1:0]    ff_grp_next;
  logic [CH_WIDTH-1:0] ff_bits;
  logic [CH_WIDTH-1:0] ff_bits_next;
  logic                clr_all;
  logic                any_new;

  assign clr_all = bus.clr_req & (&bus.clr_mask);
  assign any_new = |new_bits;

  // Scan high to low so the lowest rising group is the last one written.
  always_comb begin
    ff_grp_next  = '0;
    ff_bits_next = '0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (|new_bits[g*CH_WIDTH +: CH_WIDTH]) begin
        ff_grp_next  = GRP_W'(g);
        ff_bits_next = new_bits[g*CH_WIDTH +: CH_WIDTH];
      end
    end
  end

  // A rise landing on the same edge as a full clear re-arms and captures.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ff_valid <= 1'b0;
      ff_grp   <= '0;
      ff_bits  <= '0;
    end else if (any_new && (!ff_valid || clr_all)) begin
      ff_valid <= 1'b1;
      ff_grp   <= ff_grp_next;
      ff_bits  <= ff_bits_next;
    end else if (clr_all) begin
      ff_valid <= 1'b0;
    end
  end

  assign bus.first_valid = ff_valid;
  assign bus.first_grp   = ff_grp;
  assign bus.first_bits  = ff_bits;
`endif

endmodule

// File: tb/tb_shim_sts_sync_sticky.sv
module tb_shim_sts_sync_sticky;

  localparam int NG  = 13;
  localparam int CW  = 8;
  localparam int SD  = 3;
  localparam int SC  = 2;
  localparam int W   = NG * CW;
  localparam int LAT = SD + SC + 1;

  typedef struct {
    int            grp;
    logic [CW-1:0] val;
    logic [CW-1:0] exp_stable;
    logic [CW-1:0] exp_sticky;
    logic          exp_irq;
  } vec_t;

  logic aclk;
  logic aresetn;

  shim_sts_sync_sticky_if #(.NUM_GROUPS(NG), .CH_WIDTH(CW)) bus ();

  shim_sts_sync_sticky #(
    .NUM_GROUPS   (NG),
    .CH_WIDTH     (CW),
    .SYNC_DEPTH   (SD),
    .STABLE_COUNT (SC)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_sticky_full;
  logic [W-1:0]  drv;
  logic [W-1:0]  mon_exp;
  vec_t          vecs[7];

  // ---------------- clock / watchdog ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / drivers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_group(input int g, input logic [CW-1:0] val);
    drv[g*CW +: CW] = val;
    bus.sts_in = drv;
  endtask

  function automatic logic [CW-1:0] stable_g(input int g);
    return bus.sts_stable[g*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] sticky_g(input int g);
    return bus.sts_sticky[g*CW +: CW];
  endfunction

  task automatic clear(input logic [NG-1:0] mask);
    bus.clr_req  = 1'b1;
    bus.clr_mask = mask;
    tick();
    bus.clr_req  = 1'b0;
    bus.clr_mask = '0;
  endtask

  // Clean held step on one group, checked edge by edge.
  task automatic run_vec(input int idx, input vec_t v);
    logic [CW-1:0] old_stable;
    logic [CW-1:0] old_sticky;
    old_stable = drv[v.grp*CW +: CW];
    old_sticky = exp_sticky_full[v.grp*CW +: CW];
    set_group(v.grp, v.val);
    exp_sticky_full[v.grp*CW +: CW] = v.exp_sticky;
    if (v.exp_irq) exp_q.push_back(exp_sticky_full);
    for (int e = 1; e <= LAT + 2; e++) begin
      tick();
      if (e == LAT - 1)
        check($sformatf("vec%0d_stable_early", idx), stable_g(v.grp), old_stable);
      if (e == LAT) begin
        check($sformatf("vec%0d_stable", idx), stable_g(v.grp), v.exp_stable);
        check($sformatf("vec%0d_sticky_early", idx), sticky_g(v.grp), old_sticky);
      end
      if (e == LAT + 1) begin
        check($sformatf("vec%0d_sticky", idx), bus.sts_sticky, exp_sticky_full);
        check($sformatf("vec%0d_irq", idx), bus.irq_pulse, v.exp_irq);
        check($sformatf("vec%0d_grp_any", idx), bus.grp_any[v.grp], |v.exp_sticky);
      end
      if (e == LAT + 2)
        check($sformatf("vec%0d_irq_single", idx), bus.irq_pulse, 1'b0);
    end
    tick();
    tick();
  endtask

  // ---------------- scoreboard: every irq pops one expected sticky image ----
  always @(negedge aclk) begin
    if (aresetn && bus.irq_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL irq_unexpected actual=1 expected=0 sticky=%0h", bus.sts_sticky);
      end else begin
        mon_exp = exp_q.pop_front();
        check("irq_sticky_image", bus.sts_sticky, mon_exp);
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    int seen;
    int acks;

    vecs[0] = '{2,  8'h05, 8'h05, 8'h05, 1'b1};
    vecs[1] = '{5,  8'h3C, 8'h3C, 8'h3C, 1'b1};
    vecs[2] = '{4,  8'hFF, 8'hFF, 8'hFF, 1'b1};
    vecs[3] = '{12, 8'h81, 8'h81, 8'h81, 1'b1};
    vecs[4] = '{2,  8'h0F, 8'h0F, 8'h0F, 1'b1};
    vecs[5] = '{2,  8'h00, 8'h00, 8'h0F, 1'b0};
    vecs[6] = '{2,  8'h05, 8'h05, 8'h0F, 1'b0};

    aresetn         = 1'b0;
    drv             = '0;
    exp_sticky_full = '0;
    bus.sts_in      = '0;
    bus.clr_req     = 1'b0;
    bus.clr_mask    = '0;
    tick();
    tick();
    check("rst_stable", bus.sts_stable, '0);
    check("rst_sticky", bus.sts_sticky, '0);
    check("rst_grp_any", bus.grp_any, '0);
    check("rst_irq", bus.irq_pulse, 1'b0);
    check("rst_ack", bus.clr_ack, 1'b0);
`ifdef STS_FIRST_FAULT_EN
    check("rst_first_valid", bus.first_valid, 1'b0);
`endif
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Table-driven clean steps.
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Two-cycle glitch never reaches stable/sticky.
    set_group(0, 8'h08);
    tick();
    tick();
    set_group(0, 8'h00);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (stable_g(0) != 8'h00) seen++;
    end
    check("glitch2_stable_seen", seen, 0);
    check("glitch2_sticky", sticky_g(0), 8'h00);

    // Three-cycle pulse is just long enough to pass the filter.
    exp_sticky_full[0 +: CW] = 8'h08;
    exp_q.push_back(exp_sticky_full);
    set_group(0, 8'h08);
    tick();
    tick();
    tick();
    set_group(0, 8'h00);
    for (int i = 0; i < 12; i++) tick();
    check("pulse3_sticky", sticky_g(0), 8'h08);
    check("pulse3_stable_back", stable_g(0), 8'h00);

    // Masked clear of group 4 while its input stays high.
    exp_sticky_full[4*CW +: CW] = 8'h00;
    clear(NG'(1) << 4);
    check("clr4_sticky", bus.sts_sticky, exp_sticky_full);
    check("clr4_ack", bus.clr_ack, 1'b1);
    check("clr4_grp_any4", bus.grp_any[4], 1'b0);
    check("clr4_grp_any2", bus.grp_any[2], 1'b1);
    tick();
    check("clr4_ack_drop", bus.clr_ack, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("clr4_no_reset", bus.sts_sticky, exp_sticky_full);

    // clr_req held three cycles with an empty mask: three acks, no change.
    acks = 0;
    bus.clr_req  = 1'b1;
    bus.clr_mask = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(bus.clr_ack);
    end
    bus.clr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(bus.clr_ack);
    end
    check("held_clr_acks", acks, 3);
    check("held_clr_sticky", bus.sts_sticky, exp_sticky_full);

    // Clear of group 1 on the same edge bit 0 sets: set wins, bit 7 clears.
    run_vec(7, '{1, 8'h80, 8'h80, 8'h80, 1'b1});
    set_group(1, 8'h81);
    for (int i = 0; i < LAT; i++) tick();
    check("same_edge_stable", stable_g(1), 8'h81);
    check("same_edge_sticky_pre", sticky_g(1), 8'h80);
    bus.clr_req  = 1'b1;
    bus.clr_mask = NG'(1) << 1;
    exp_sticky_full[1*CW +: CW] = 8'h01;
    exp_q.push_back(exp_sticky_full);
    tick();
    bus.clr_req  = 1'b0;
    bus.clr_mask = '0;
    check("same_edge_sticky", sticky_g(1), 8'h01);
    check("same_edge_irq", bus.irq_pulse, 1'b1);
    check("same_edge_ack", bus.clr_ack, 1'b1);
    tick();
    check("same_edge_irq_drop", bus.irq_pulse, 1'b0);

    // Reset mid-filter (count = 1) with 8'hAA held on group 6.
    set_group(6, 8'hAA);
    for (int i = 0; i < LAT - 1; i++) tick();
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_stable", bus.sts_stable, '0);
    check("midrst_sticky", bus.sts_sticky, '0);
    check("midrst_grp_any", bus.grp_any, '0);
    check("midrst_irq", bus.irq_pulse, 1'b0);
    check("midrst_ack", bus.clr_ack, 1'b0);
    tick();
    tick();
    aresetn = 1'b1;
    exp_sticky_full = drv;
    exp_q.push_back(exp_sticky_full);
    for (int e = 1; e <= LAT + 2; e++) begin
      tick();
      if (e == LAT - 1) check("postrst_stable_early", bus.sts_stable, '0);
      if (e == LAT) check("postrst_stable", bus.sts_stable, drv);
      if (e == LAT + 1) begin
        check("postrst_sticky", bus.sts_sticky, drv);
        check("postrst_irq", bus.irq_pulse, 1'b1);
        check("postrst_grp6_stable", stable_g(6), 8'hAA);
      end
      if (e == LAT + 2) check("postrst_irq_single", bus.irq_pulse, 1'b0);
    end

    // Full clear, then simultaneous rises in groups 3 and 7, then group 1.
    exp_sticky_full = '0;
    clear('1);
    check("clrall_sticky", bus.sts_sticky, '0);
    check("clrall_grp_any", bus.grp_any, '0);
`ifdef STS_FIRST_FAULT_EN
    check("clrall_first_valid", bus.first_valid, 1'b0);
`endif
    set_group(3, 8'h11);
    set_group(7, 8'h22);
    exp_sticky_full[3*CW +: CW] = 8'h11;
    exp_sticky_full[7*CW +: CW] = 8'h22;
    exp_q.push_back(exp_sticky_full);
    for (int i = 0; i < LAT + 1; i++) tick();
    check("ff_sticky_37", bus.sts_sticky, exp_sticky_full);
    check("ff_irq_37", bus.irq_pulse, 1'b1);
`ifdef STS_FIRST_FAULT_EN
    check("ff_valid", bus.first_valid, 1'b1);
    check("ff_grp", bus.first_grp, 3);
    check("ff_bits", bus.first_bits, 8'h11);
`endif
    tick();
    set_group(1, 8'h83);
    exp_sticky_full[1*CW +: CW] = 8'h02;
    exp_q.push_back(exp_sticky_full);
    for (int i = 0; i < LAT + 1; i++) tick();
    check("ff_sticky_g1", sticky_g(1), 8'h02);
    check("ff_irq_g1", bus.irq_pulse, 1'b1);
`ifdef STS_FIRST_FAULT_EN
    check("ff_grp_kept", bus.first_grp, 3);
    check("ff_bits_kept", bus.first_bits, 8'h11);
`endif
    tick();
    exp_sticky_full = '0;
    clear('1);
    check("final_clr_sticky", bus.sts_sticky, '0);
`ifdef STS_FIRST_FAULT_EN
    check("ff_valid_cleared", bus.first_valid, 1'b0);
`endif

    for (int i = 0; i < 4; i++) tick();
    check("irq_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
